// File: rtl/sram_uart_dump.sv
// Streams a block of 16-bit SRAM words out on an 8N1 UART, high byte first.
// Optional PPM_HEADER_EN: prefix the dump with a 15-byte PPM P6 header held in ROM.
module sram_uart_dump #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 18
) (
  input  logic              Clock_50,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Base_address,
  input  logic [ADDR_W-1:0] Word_count,
  output logic [ADDR_W-1:0] SRAM_address,
  input  logic [15:0]       SRAM_read_data,
  output logic              SRAM_we_n,
  output logic              UART_TX_O,
  output logic              Busy,
  output logic              Done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_WAIT1   = 3'd3;
  localparam logic [2:0] S_WAIT2   = 3'd4;
  localparam logic [2:0] S_SEND_HI = 3'd5;
  localparam logic [2:0] S_SEND_LO = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [15:0]       hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [1:0]        tx_state_q, tx_state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_line_q, tx_line_d;

  logic              tx_go_c;
  logic              tx_done_c;
  logic [7:0]        tx_data_c;

`ifdef PPM_HEADER_EN
  localparam logic [3:0] HDR_LAST = 4'd14;
  logic [3:0] hdr_idx_q, hdr_idx_d;

  // "P6\n320 240\n255\n"
  function automatic logic [7:0] hdr_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    hdr_rom = 8'h50;
      4'd1:    hdr_rom = 8'h36;
      4'd2:    hdr_rom = 8'h0A;
      4'd3:    hdr_rom = 8'h33;
      4'd4:    hdr_rom = 8'h32;
      4'd5:    hdr_rom = 8'h30;
      4'd6:    hdr_rom = 8'h20;
      4'd7:    hdr_rom = 8'h32;
      4'd8:    hdr_rom = 8'h34;
      4'd9:    hdr_rom = 8'h30;
      4'd10:   hdr_rom = 8'h0A;
      4'd11:   hdr_rom = 8'h32;
      4'd12:   hdr_rom = 8'h35;
      4'd13:   hdr_rom = 8'h35;
      4'd14:   hdr_rom = 8'h0A;
      default: hdr_rom = 8'h00;
    endcase
  endfunction
`endif

  // Byte launch is level-based: the TX engine only accepts it while idle, and the main
  // FSM leaves a send state on the same edge the engine returns to idle.
  assign tx_go_c   = (tx_state_q == TX_IDLE) &&
                     (state_q == S_SEND_HI || state_q == S_SEND_LO || state_q == S_HEADER);
  assign tx_done_c = (tx_state_q == TX_STOP) && (baud_q == BAUD_LAST);

  always_comb begin
    tx_data_c = 8'h00;
    if (state_q == S_SEND_HI)      tx_data_c = hold_q[15:8];
    else if (state_q == S_SEND_LO) tx_data_c = hold_q[7:0];
`ifdef PPM_HEADER_EN
    else if (state_q == S_HEADER)  tx_data_c = hdr_rom(hdr_idx_q);
`endif
  end

  // Main sequencing FSM
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef PPM_HEADER_EN
    hdr_idx_d = hdr_idx_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          addr_d = Base_address;
          rem_d  = Word_count;
          busy_d = 1'b1;
`ifdef PPM_HEADER_EN
          hdr_idx_d = 4'd0;
          state_d   = S_HEADER;
`else
          state_d = (Word_count == '0) ? S_DONE : S_REQ;
`endif
        end
      end
`ifdef PPM_HEADER_EN
      S_HEADER: begin
        if (tx_done_c) begin
          if (hdr_idx_q == HDR_LAST) state_d = (rem_q == '0) ? S_DONE : S_REQ;
          else                       hdr_idx_d = hdr_idx_q + 4'd1;
        end
      end
`endif
      S_REQ:     state_d = S_WAIT1;
      S_WAIT1:   state_d = S_WAIT2;
      S_WAIT2: begin
        hold_d  = SRAM_read_data;
        state_d = S_SEND_HI;
      end
      S_SEND_HI: if (tx_done_c) state_d = S_SEND_LO;
      S_SEND_LO: begin
        if (tx_done_c) begin
          rem_d = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_REQ;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // UART transmitter: start, 8 data LSB first, stop; each bit CLKS_PER_BIT cycles
  always_comb begin
    tx_state_d = tx_state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    tx_byte_d  = tx_byte_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_line_d = 1'b1;
        if (tx_go_c) begin
          tx_byte_d  = tx_data_c;
          tx_line_d  = 1'b0;
          baud_d     = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d     = '0;
          bit_d      = 4'd0;
          tx_line_d  = tx_byte_q[0];
          tx_state_d = TX_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      TX_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 4'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            bit_d     = bit_q + 4'd1;
            tx_byte_d = {1'b0, tx_byte_q[7:1]};
            tx_line_d = tx_byte_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      TX_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d     = '0;
          tx_state_d = TX_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_state_q <= TX_IDLE;
      baud_q     <= '0;
      bit_q      <= 4'd0;
      tx_byte_q  <= 8'h00;
      tx_line_q  <= 1'b1;
`ifdef PPM_HEADER_EN
      hdr_idx_q  <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_state_q <= tx_state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_line_q  <= tx_line_d;
`ifdef PPM_HEADER_EN
      hdr_idx_q  <= hdr_idx_d;
`endif
    end
  end

  assign SRAM_address = addr_q;
  assign SRAM_we_n    = 1'b1;
  assign UART_TX_O    = tx_line_q;
  assign Busy         = busy_q;
  assign Done         = done_q;

endmodule

// File: tb/tb_sram_uart_dump.sv
// Bench for sram_uart_dump: SRAM model with 2-cycle read latency, UART receiver, byte-stream model.
module tb_sram_uart_dump;
  localparam int C  = 16;
  localparam int AW = 18;
`ifdef PPM_HEADER_EN
  localparam int HL = 15;
`else
  localparam int HL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_in = '0;
  logic [AW-1:0] cnt_in = '0;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_rd;
  logic          we_n, tx, busy, done;

  sram_uart_dump #(.CLKS_PER_BIT(C), .ADDR_W(AW)) dut (
    .Clock_50(clk), .Reset(rst), .Start(start), .Base_address(base_in), .Word_count(cnt_in),
    .SRAM_address(sram_addr), .SRAM_read_data(sram_rd), .SRAM_we_n(we_n),
    .UART_TX_O(tx), .Busy(busy), .Done(done)
  );

  always #10 clk = ~clk;

  logic [15:0] mem [0:(1<<AW)-1];
  logic [15:0] rd1, rd2;
  always @(posedge clk) begin
    rd1 <= mem[sram_addr];
    rd2 <= rd1;
  end
  assign sram_rd = rd2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Done / busy / line / address monitors
  int done_cnt = 0, done_cyc = 0, busy_bad = 0, tx_low_cnt = 0;
  logic [AW-1:0] addr_seen[$];
  logic trk = 1'b0;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (done === 1'b1) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
        if (busy !== 1'b0) busy_bad = busy_bad + 1;
      end
      if (tx === 1'b0) tx_low_cnt = tx_low_cnt + 1;
      if (busy === 1'b1 && (!trk || sram_addr != addr_seen[$])) addr_seen.push_back(sram_addr);
      trk = busy;
    end else begin
      trk = 1'b0;
    end
  end

  // UART receiver: every cycle of each bit must hold the same level
  logic [7:0] rx_q[$];
  int         rx_start[$];
  int         rx_end[$];
  int         rx_bad = 0;
  logic [9:0] rx_bits;
  bit         rx_ok, rx_abort;
  int         rx_s;
  always begin
    @(negedge clk);
    if (rst === 1'b0 && tx === 1'b0) begin
      rx_s = cyc; rx_ok = 1'b1; rx_abort = 1'b0;
      for (int k = 0; k < 10; k++) begin
        for (int j = 0; j < C; j++) begin
          if (k != 0 || j != 0) @(negedge clk);
          if (rst !== 1'b0) rx_abort = 1'b1;
          if (j == 0) rx_bits[k] = tx;
          else if (tx !== rx_bits[k]) rx_ok = 1'b0;
        end
      end
      if (!rx_abort) begin
        if (rx_ok && rx_bits[0] == 1'b0 && rx_bits[9] == 1'b1) begin
          rx_q.push_back(rx_bits[8:1]);
          rx_start.push_back(rx_s);
          rx_end.push_back(rx_s + 10*C - 1);
        end else begin
          rx_bad++;
        end
      end
    end
  end

  string         hdr = "P6\n320 240\n255\n";
  logic [7:0]    exp_q[$];
  logic [AW-1:0] exp_addr[$];
  int            st_cyc;

  task automatic start_dump(input logic [AW-1:0] b, input logic [AW-1:0] n);
    logic [AW-1:0] a;
    exp_q.delete(); exp_addr.delete();
    for (int i = 0; i < HL; i++) exp_q.push_back(hdr[i]);
    for (int i = 0; i < int'(n); i++) begin
      a = AW'(b + AW'(i));
      exp_addr.push_back(a);
      exp_q.push_back(mem[a][15:8]);
      exp_q.push_back(mem[a][7:0]);
    end
    rx_q.delete(); rx_start.delete(); rx_end.delete(); addr_seen.delete();
    rx_bad = 0; done_cnt = 0; busy_bad = 0; tx_low_cnt = 0;
    @(negedge clk);
    base_in = b; cnt_in = n; start = 1'b1; st_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic finish_dump(input string tag, input int n_words);
    int budget, waited, mism, max_gap, lo_bad, g;
    budget = (exp_q.size() + 2) * (10*C + 10) + 50;
    waited = 0;
    while (done_cnt == 0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (20) @(negedge clk);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy_bad), 32'd0);
    chk({tag, "_frame_err"}, 32'(rx_bad), 32'd0);
    chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
    mism = 0;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) mism++;
    chk({tag, "_bytes"}, 32'(mism), 32'd0);
    max_gap = 0; lo_bad = 0;
    for (int k = 1; k < rx_start.size(); k++) begin
      g = rx_start[k] - (rx_start[k-1] + 10*C);
      if (g > max_gap || g < 0) max_gap = (g < 0) ? 999 : g;
      if (k >= HL && ((k - HL) % 2 == 1) && g > 4) lo_bad++;
    end
    chk({tag, "_gap_max8"}, 32'(max_gap <= 8), 32'd1);
    chk({tag, "_gap_hilo4"}, 32'(lo_bad), 32'd0);
    if (rx_end.size() > 0) begin
      g = done_cyc - rx_end[$];
      chk({tag, "_done_lag"}, 32'(g >= 1 && g <= 2), 32'd1);
    end
    if (n_words > 0) begin
      chk({tag, "_naddr"}, 32'(addr_seen.size()), 32'(exp_addr.size()));
      mism = 0;
      for (int i = 0; i < addr_seen.size() && i < exp_addr.size(); i++)
        if (addr_seen[i] !== exp_addr[i]) mism++;
      chk({tag, "_addr_seq"}, 32'(mism), 32'd0);
    end
  endtask

  task automatic wait_tx_low(input string tag);
    int w;
    w = 0;
    while (tx !== 1'b0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_tx_began"}, 32'(tx === 1'b0), 32'd1);
  endtask

  initial begin
    logic [AW-1:0] rb, rn;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_we_n", 32'(we_n), 32'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single word
    mem[18'h00100] = 16'hA55A;
    start_dump(18'h00100, 18'd1);
    finish_dump("one", 1);

    // Zero words
    start_dump(18'h00055, 18'd0);
`ifdef PPM_HEADER_EN
    finish_dump("zero", 0);
`else
    repeat (10) @(negedge clk);
    chk("zero_done_cnt", 32'(done_cnt), 32'd1);
    chk("zero_done_lat", 32'(done_cyc - st_cyc), 32'd2);
    chk("zero_tx_idle", 32'(tx_low_cnt), 32'd0);
`endif

    // Address wrap
    mem[18'h3FFFF] = 16'h1234;
    mem[18'h00000] = 16'hBEEF;
    start_dump(18'h3FFFF, 18'd2);
    finish_dump("wrap", 2);

    // Start re-pulsed while busy must be ignored
    mem[18'h01000] = 16'h0102; mem[18'h01001] = 16'hF00D; mem[18'h01002] = 16'h8001;
    start_dump(18'h01000, 18'd3);
    wait_tx_low("repulse");
    @(negedge clk);
    base_in = 18'h02222; cnt_in = 18'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_dump("repulse", 3);

    // Reset in the middle of data bit 3
    mem[18'h02000] = 16'hC3C3; mem[18'h02001] = 16'h3C3C;
    start_dump(18'h02000, 18'd2);
    wait_tx_low("midrst");
    repeat (4*C + C/2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10*C + 20) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    mem[18'h03000] = 16'h5AA5; mem[18'h03001] = 16'h0FF0;
    start_dump(18'h03000, 18'd2);
    finish_dump("after_rst", 2);

    // Randomized dumps
    for (int t = 0; t < 3; t++) begin
      rb = AW'($urandom);
      rn = AW'(1 + $urandom_range(2));
      for (int i = 0; i < int'(rn); i++) mem[AW'(rb + AW'(i))] = 16'($urandom);
      start_dump(rb, rn);
      finish_dump($sformatf("rand%0d", t), int'(rn));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end
endmodule
